// File: rtl/remap_pkg.sv
// rtl/remap_pkg.sv - shared types and width helpers for the bilinear remap engine
package remap_pkg;

    typedef enum logic [1:0] {TAP00, TAP01, TAP10, TAP11} tap_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_w(input int src_w, input int src_h);
        return $clog2(max2(src_w, src_h));
    endfunction

    function automatic int la_w(input int dst_w, input int dst_h);
        return $clog2(max2(dst_w, dst_h));
    endfunction

    function automatic int acc_w(input int pix_w, input int frac_w);
        return pix_w + 2 * frac_w + 2;
    endfunction

endpackage

// File: rtl/remap_lut.sv
// rtl/remap_lut.sv - mapping table RAM, one write port and one registered read port
module remap_lut #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // contents are deliberately not reset so tables survive rstn
    always_ff @(posedge clk) begin
        if (we && (int'({1'b0, waddr}) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bilinear_remap_engine.sv
// rtl/bilinear_remap_engine.sv - table-driven bilinear remap, one tap per cycle
module bilinear_remap_engine
    import remap_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int DST_W  = 260,
    parameter int DST_H  = 260,
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 20,
    localparam int IDX_W = idx_w(SRC_W, SRC_H),
    localparam int LA_W  = la_w(DST_W, DST_H),
    localparam int ACC_W = acc_w(PIX_W, FRAC_W),
    localparam int LUT_W = IDX_W + FRAC_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              lut_wr_en,
    input  logic              lut_sel,
    input  logic [LA_W-1:0]   lut_wr_addr,
    input  logic [LUT_W-1:0]  lut_wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);

    localparam int W_W = 2 * FRAC_W + 2;
    localparam logic [FRAC_W:0] ONE  = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [ACC_W:0]  HALF = (ACC_W + 1)'(1) << (2 * FRAC_W - 1);

    state_e state, state_nx;
    logic [LA_W-1:0] dst_i, dst_j;
    tap_e tap;
    logic issue, squash, last_tap, wr_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !abort) state_nx = RUN;
            RUN:     if (abort) state_nx = IDLE; else if (last_tap) state_nx = DRAIN;
            DRAIN:   if (abort || (wr_en && wr_last)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        issue    = (state == RUN) && !abort;
        squash   = abort && (state != IDLE);
        last_tap = (tap == TAP11) && (dst_i == LA_W'(DST_H - 1)) && (dst_j == LA_W'(DST_W - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dst_i <= '0;
            dst_j <= '0;
            tap   <= TAP00;
        end else if (state != RUN) begin
            dst_i <= '0;
            dst_j <= '0;
            tap   <= TAP00;
        end else begin
            tap <= tap_e'(tap + 2'd1);
            if (tap == TAP11) begin
                if (dst_j == LA_W'(DST_W - 1)) begin
                    dst_j <= '0;
                    dst_i <= dst_i + 1'b1;
                end else begin
                    dst_j <= dst_j + 1'b1;
                end
            end
        end
    end

    logic [LUT_W-1:0] row_q, col_q;
    logic lut_ok;
    assign lut_ok = lut_wr_en && (state == IDLE);

    remap_lut #(.DEPTH(DST_H), .AW(LA_W), .DW(LUT_W)) u_row_lut (
        .clk(clk), .we(lut_ok && !lut_sel), .waddr(lut_wr_addr), .wdata(lut_wr_data),
        .raddr(dst_i), .rdata(row_q)
    );

    remap_lut #(.DEPTH(DST_W), .AW(LA_W), .DW(LUT_W)) u_col_lut (
        .clk(clk), .we(lut_ok && lut_sel), .waddr(lut_wr_addr), .wdata(lut_wr_data),
        .raddr(dst_j), .rdata(col_q)
    );

    function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] x, input int size);
        return (int'({1'b0, x}) >= size) ? IDX_W'(size - 1) : x;
    endfunction

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] x, input int size);
        return (int'({1'b0, x}) >= size - 1) ? x : x + 1'b1;
    endfunction

    // stage 1: table data arrives, tap selects neighbour and weight
    logic s1_valid, s1_last;
    tap_e s1_tap;
    logic [ADDR_W-1:0] s1_waddr;
    logic [IDX_W-1:0] r0, r1, c0, c1;
    logic [FRAC_W-1:0] u, v;
    logic [FRAC_W:0] cu, cv;
    logic [W_W-1:0] w_sel;
    logic [ADDR_W-1:0] rd_addr_nx;

    always_comb begin
        v  = row_q[FRAC_W-1:0];
        u  = col_q[FRAC_W-1:0];
        r0 = clamp_idx(row_q[LUT_W-1:FRAC_W], SRC_H);
        c0 = clamp_idx(col_q[LUT_W-1:FRAC_W], SRC_W);
        r1 = step_idx(r0, SRC_H);
        c1 = step_idx(c0, SRC_W);
        cu = ONE - {1'b0, u};
        cv = ONE - {1'b0, v};
        w_sel = '0;
        case (s1_tap)
            TAP00:   w_sel = W_W'(cu) * W_W'(cv);
            TAP01:   w_sel = W_W'(u) * W_W'(cv);
            TAP10:   w_sel = W_W'(cu) * W_W'(v);
            default: w_sel = W_W'(u) * W_W'(v);
        endcase
        rd_addr_nx = ADDR_W'(s1_tap[1] ? r1 : r0) * ADDR_W'(SRC_W) + ADDR_W'(s1_tap[0] ? c1 : c0);
    end

    logic [W_W-1:0] s2_w;
    tap_e s2_tap;
    logic [ADDR_W-1:0] s2_waddr;
    logic s2_last;

    logic              d_valid [RD_LAT];
    logic [W_W-1:0]    d_w     [RD_LAT];
    tap_e              d_tap   [RD_LAT];
    logic [ADDR_W-1:0] d_waddr [RD_LAT];
    logic              d_last  [RD_LAT];

    logic p_valid, p_last;
    logic [ACC_W-1:0] p_prod, acc, acc_sum;
    tap_e p_tap;
    logic [ADDR_W-1:0] p_waddr;
    logic [ACC_W:0] rounded;
    logic [PIX_W-1:0] pix;

    always_comb begin
        acc_sum = ((p_tap == TAP00) ? '0 : acc) + p_prod;
        rounded = {1'b0, acc_sum} + HALF;
        pix     = (|(rounded >> (2 * FRAC_W + PIX_W))) ? '1 : rounded[2*FRAC_W +: PIX_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0; s1_tap <= TAP00; s1_waddr <= '0; s1_last <= 1'b0;
            rd_en <= 1'b0; rd_addr <= '0; s2_w <= '0; s2_tap <= TAP00; s2_waddr <= '0; s2_last <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                d_valid[k] <= 1'b0; d_w[k] <= '0; d_tap[k] <= TAP00; d_waddr[k] <= '0; d_last[k] <= 1'b0;
            end
            p_valid <= 1'b0; p_prod <= '0; p_tap <= TAP00; p_waddr <= '0; p_last <= 1'b0;
            acc <= '0; wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; wr_last <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_tap   <= tap;
                s1_waddr <= ADDR_W'(dst_i) * ADDR_W'(DST_W) + ADDR_W'(dst_j);
                s1_last  <= last_tap;
            end
            rd_en <= s1_valid && !squash;
            if (s1_valid) begin
                rd_addr <= rd_addr_nx; s2_w <= w_sel; s2_tap <= s1_tap;
                s2_waddr <= s1_waddr; s2_last <= s1_last;
            end
            // weight and tag ride alongside the frame-memory read latency
            d_valid[0] <= rd_en && !squash;
            d_w[0] <= s2_w; d_tap[0] <= s2_tap; d_waddr[0] <= s2_waddr; d_last[0] <= s2_last;
            for (int k = 1; k < RD_LAT; k++) begin
                d_valid[k] <= d_valid[k-1] && !squash;
                d_w[k] <= d_w[k-1]; d_tap[k] <= d_tap[k-1];
                d_waddr[k] <= d_waddr[k-1]; d_last[k] <= d_last[k-1];
            end
            p_valid <= d_valid[RD_LAT-1] && !squash;
            if (d_valid[RD_LAT-1]) begin
                p_prod  <= ACC_W'(d_w[RD_LAT-1]) * ACC_W'(rd_data);
                p_tap   <= d_tap[RD_LAT-1];
                p_waddr <= d_waddr[RD_LAT-1];
                p_last  <= d_last[RD_LAT-1];
            end
            if (p_valid) acc <= acc_sum;
            wr_en   <= p_valid && (p_tap == TAP11) && !squash;
            wr_last <= p_valid && (p_tap == TAP11) && p_last && !squash;
            if (p_valid && (p_tap == TAP11)) begin
                wr_addr <= p_waddr;
                wr_data <= pix;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) done <= 1'b0;
        else       done <= (state == DRAIN) && wr_en && wr_last && !abort;
    end

endmodule

// File: tb/tb_bilinear_remap_engine.sv
// tb/tb_bilinear_remap_engine.sv - scoreboard bench for bilinear_remap_engine
module tb_bilinear_remap_engine;

    localparam int SRC_W = 8, SRC_H = 6, DST_W = 8, DST_H = 6;
    localparam int PIX_W = 8, FRAC_W = 8, RD_LAT = 2, ADDR_W = 12;
    localparam int IDX_W = 3, LA_W = 3, LUT_W = IDX_W + FRAC_W;
    localparam int NPIX = DST_W * DST_H, NSRC = SRC_W * SRC_H;
    localparam int FRAME_CYC = 4 * NPIX + RD_LAT + 5;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic lut_wr_en = 1'b0, lut_sel = 1'b0;
    logic [LA_W-1:0] lut_wr_addr = '0;
    logic [LUT_W-1:0] lut_wr_data = '0;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [PIX_W-1:0] rd_data, wr_data;

    bilinear_remap_engine #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
        .PIX_W(PIX_W), .FRAC_W(FRAC_W), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
        .lut_wr_en(lut_wr_en), .lut_sel(lut_sel), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0] mem [NSRC];
    logic [PIX_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= (int'(rd_addr) < NSRC) ? mem[rd_addr] : '0;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    logic [LUT_W-1:0] row_tab [DST_H];
    logic [LUT_W-1:0] col_tab [DST_W];

    function automatic int src_px(input int r, input int c);
        return int'(mem[r * SRC_W + c]);
    endfunction

    function automatic int model_px(input int i, input int j);
        int r, c, r1, c1, u, v, cu, cv, sum, res;
        r = int'(row_tab[i]) >> FRAC_W;  v = int'(row_tab[i]) % (1 << FRAC_W);
        c = int'(col_tab[j]) >> FRAC_W;  u = int'(col_tab[j]) % (1 << FRAC_W);
        if (r > SRC_H - 1) r = SRC_H - 1;
        if (c > SRC_W - 1) c = SRC_W - 1;
        r1 = (r + 1 > SRC_H - 1) ? SRC_H - 1 : r + 1;
        c1 = (c + 1 > SRC_W - 1) ? SRC_W - 1 : c + 1;
        cu = (1 << FRAC_W) - u;  cv = (1 << FRAC_W) - v;
        sum = cu * cv * src_px(r, c) + u * cv * src_px(r, c1) + cu * v * src_px(r1, c) + u * v * src_px(r1, c1);
        res = (sum + (1 << (2 * FRAC_W - 1))) >> (2 * FRAC_W);
        return (res > (1 << PIX_W) - 1) ? (1 << PIX_W) - 1 : res;
    endfunction

    typedef struct {int addr; int data;} exp_t;
    exp_t sb_q[$];
    int checks = 0, failures = 0;
    int out_arr [NPIX];
    int done_cnt = 0, wr_cnt = 0, quiet_bad = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn && wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write: got addr %0d required no write", wr_addr);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
            if (int'(wr_addr) < NPIX) out_arr[wr_addr] = int'(wr_data);
        end
        if (rstn && done) begin
            done_cnt++;
            check("busy_low_with_done", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic lut_write(input logic sel, input int addr, input logic [LUT_W-1:0] data);
        lut_wr_en = 1'b1; lut_sel = sel; lut_wr_addr = LA_W'(addr); lut_wr_data = data;
        tick();
        lut_wr_en = 1'b0;
    endtask

    task automatic load_tables();
        for (int i = 0; i < DST_H; i++) lut_write(1'b0, i, row_tab[i]);
        for (int j = 0; j < DST_W; j++) lut_write(1'b1, j, col_tab[j]);
    endtask

    task automatic randomize_all(input int max_idx);
        for (int i = 0; i < DST_H; i++) row_tab[i] = {IDX_W'($urandom_range(max_idx)), FRAC_W'($urandom)};
        for (int j = 0; j < DST_W; j++) col_tab[j] = {IDX_W'($urandom_range(max_idx)), FRAC_W'($urandom)};
        for (int a = 0; a < NSRC; a++) mem[a] = PIX_W'($urandom);
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < DST_H; i++)
            for (int j = 0; j < DST_W; j++) begin
                e.addr = i * DST_W + j;
                e.data = model_px(i, j);
                sb_q.push_back(e);
            end
        for (int a = 0; a < NPIX; a++) out_arr[a] = -1;
    endtask

    task automatic run_frame(input string name, input bit disturb);
        int k, dc;
        dc = done_cnt;
        push_expected();
        start = 1'b1; tick(); start = 1'b0;
        k = 1;
        while (!done && k < FRAME_CYC + 50) begin
            if (disturb && k == 40) begin
                start = 1'b1; lut_wr_en = 1'b1; lut_sel = 1'b0;
                lut_wr_addr = '0; lut_wr_data = ~row_tab[0];
            end
            tick(); k++;
            start = 1'b0; lut_wr_en = 1'b0;
        end
        check({name, "_latency"}, k, FRAME_CYC);
        check({name, "_all_written"}, sb_q.size(), 0);
        sb_q.delete();
        tick();
        check({name, "_done_once"}, done_cnt, dc + 1);
        check({name, "_done_pulse"}, {done, busy}, 0);
    endtask

    initial begin
        int ok, dc, wc, k;
        repeat (3) tick();
        check("reset_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        rstn = 1'b1; tick();

        for (int i = 0; i < DST_H; i++) row_tab[i] = {IDX_W'(i), FRAC_W'(0)};
        for (int j = 0; j < DST_W; j++) col_tab[j] = {IDX_W'(j), FRAC_W'(0)};
        for (int a = 0; a < NSRC; a++) mem[a] = PIX_W'(a);
        load_tables();
        run_frame("identity", 1'b0);
        ok = 0;
        for (int a = 0; a < NPIX; a++) if (out_arr[a] == a) ok++;
        check("identity_values", ok, NPIX);

        randomize_all(7);
        row_tab[0] = {IDX_W'(0), FRAC_W'(128)}; col_tab[0] = {IDX_W'(0), FRAC_W'(128)};
        mem[0] = 10; mem[1] = 20; mem[SRC_W] = 30; mem[SRC_W + 1] = 40;
        load_tables();
        run_frame("center", 1'b0);
        check("center_blend", out_arr[0], 25);

        row_tab[0] = {IDX_W'(SRC_H - 1), FRAC_W'(200)};
        mem[(SRC_H - 1) * SRC_W] = 0; mem[(SRC_H - 1) * SRC_W + 1] = 100;
        load_tables();
        run_frame("row_clamp", 1'b0);
        check("row_clamp_blend", out_arr[0], 50);

        for (int i = 0; i < DST_H; i++) row_tab[i] = {IDX_W'($urandom_range(7)), FRAC_W'(1)};
        for (int j = 0; j < DST_W; j++) col_tab[j] = {IDX_W'($urandom_range(7)), FRAC_W'(1)};
        for (int a = 0; a < NSRC; a++) mem[a] = 8'd255;
        load_tables();
        run_frame("saturate", 1'b0);
        ok = 0;
        for (int a = 0; a < NPIX; a++) if (out_arr[a] == 255) ok++;
        check("saturate_values", ok, NPIX);

        for (int n = 0; n < 3; n++) begin
            randomize_all(7);
            load_tables();
            lut_write(1'b0, DST_H, '1);
            lut_write(1'b0, DST_H + 1, '0);
            run_frame("random", 1'b0);
        end

        run_frame("busy_ignore", 1'b1);
        run_frame("tables_kept", 1'b0);

        dc = done_cnt;
        push_expected();
        start = 1'b1; tick(); start = 1'b0;
        for (k = 1; k < 100; k++) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        sb_q.delete();
        wc = wr_cnt;
        check("abort_busy", busy, 0);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);
        quiet_bad = 0;
        repeat (FRAME_CYC) begin
            tick();
            if (rd_en || wr_en || busy) quiet_bad++;
        end
        check("abort_quiet", quiet_bad, 0);
        check("abort_no_write", wr_cnt, wc);
        check("abort_no_done", done_cnt, dc);

        push_expected();
        start = 1'b1; tick(); start = 1'b0;
        repeat (60) tick();
        rstn = 1'b0; #1;
        check("midframe_reset_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
        sb_q.delete();
        tick(); tick();
        rstn = 1'b1; tick();
        run_frame("after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
